// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Op request handshake plus ALU operand/control/result bus for
//               the ALU op sequencer. master = requester/ALU side,
//               slave = sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] alu_z;
  logic [7:0] alu_flags;
  logic [7:0] alu_a;
  logic [7:0] alu_x;
  logic [2:0] opsel;
  logic       a_inv;
  logic       x_inv;
  logic       op_inv;
  logic       carry_in;
  logic [7:0] acc;
  logic [7:0] flags;
  logic       done;
  logic       err;

  modport master (
    output op_valid, opcode, operand, alu_z, alu_flags,
    input  op_ready, alu_a, alu_x, opsel, a_inv, x_inv, op_inv, carry_in,
           acc, flags, done, err
  );

  modport slave (
    input  op_valid, opcode, operand, alu_z, alu_flags,
    output op_ready, alu_a, alu_x, opsel, a_inv, x_inv, op_inv, carry_in,
           acc, flags, done, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Control side of the 8-bit ALU. Accepts one op at a time,
//               drives ALU operands/controls, captures the ALU result and
//               writes back accumulator and flags {S,Z,0,AC,0,P,0,C}.
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
  parameter logic [7:0] ACC_RESET   = 8'h00,
  parameter logic [7:0] FLAGS_RESET = 8'h00
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_XNOR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADC  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SBB  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_RRC  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_LDA  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;

  state_t     state_q,    state_d;
  logic [7:0] acc_q,      acc_d;
  logic [7:0] flags_q,    flags_d;
  logic [7:0] alu_x_q,    alu_x_d;
  logic [2:0] opsel_q,    opsel_d;
  logic       a_inv_q,    a_inv_d;
  logic       x_inv_q,    x_inv_d;
  logic       op_inv_q,   op_inv_d;
  logic       carry_in_q, carry_in_d;
  logic [3:0] opcode_q,   opcode_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;

  logic [2:0] dec_opsel;
  logic       dec_a_inv, dec_x_inv, dec_op_inv, dec_cin;
  logic [7:0] dec_x;
  logic       res_c, res_ac;
  logic [7:0] res_flags;

  // Decode the incoming opcode into ALU controls; carry-in comes from C as held now
  always_comb begin
    dec_opsel  = 3'b000;
    dec_a_inv  = 1'b0;
    dec_x_inv  = 1'b0;
    dec_op_inv = 1'b0;
    dec_cin    = 1'b0;
    dec_x      = bus.operand;
    case (bus.opcode)
      OP_OR:           begin dec_a_inv = 1'b1; dec_x_inv = 1'b1; dec_op_inv = 1'b1; end
      OP_XOR:          dec_opsel = 3'b001;
      OP_XNOR:         begin dec_opsel = 3'b001; dec_op_inv = 1'b1; end
      OP_ADD:          dec_opsel = 3'b010;
      OP_ADC:          begin dec_opsel = 3'b010; dec_cin = flags_q[0]; end
      OP_SUB, OP_CMP:  begin dec_opsel = 3'b010; dec_x_inv = 1'b1; dec_cin = 1'b1; end
      OP_SBB:          begin dec_opsel = 3'b010; dec_x_inv = 1'b1; dec_cin = ~flags_q[0]; end
      OP_SHR:          dec_opsel = 3'b011;
      OP_RRC:          begin dec_opsel = 3'b011; dec_cin = flags_q[0]; end
      OP_NOT:          begin dec_x = 8'h00; dec_x_inv = 1'b1; dec_op_inv = 1'b1; end
      default:         ;
    endcase
  end

  // Build the new flag byte from the ALU result of the op in flight
  always_comb begin
    res_c  = 1'b0;
    res_ac = 1'b0;
    case (opcode_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP: begin
        res_c  = bus.alu_flags[0];
        res_ac = bus.alu_flags[4];
      end
      OP_SHR, OP_RRC: res_c = acc_q[0];
      default:        ;
    endcase
    res_flags = {bus.alu_z[7], (bus.alu_z == 8'h00), 1'b0, res_ac,
                 1'b0, ~^bus.alu_z, 1'b0, res_c};
  end

  // Next-state: latch controls at accept, write back in EXEC, pulse done/err
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flags_d    = flags_q;
    alu_x_d    = alu_x_q;
    opsel_d    = opsel_q;
    a_inv_d    = a_inv_q;
    x_inv_d    = x_inv_q;
    op_inv_d   = op_inv_q;
    carry_in_d = carry_in_q;
    opcode_d   = opcode_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          state_d    = ST_EXEC;
          opcode_d   = bus.opcode;
          alu_x_d    = dec_x;
          opsel_d    = dec_opsel;
          a_inv_d    = dec_a_inv;
          x_inv_d    = dec_x_inv;
          op_inv_d   = dec_op_inv;
          carry_in_d = dec_cin;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        case (opcode_q)
          OP_LDA:               acc_d   = alu_x_q;
          OP_CMP:               flags_d = res_flags;
          4'd13, 4'd14, 4'd15:  err_d   = 1'b1;
          default: begin
            acc_d   = bus.alu_z;
            flags_d = res_flags;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= ACC_RESET;
      flags_q    <= FLAGS_RESET;
      alu_x_q    <= 8'h00;
      opsel_q    <= 3'b000;
      a_inv_q    <= 1'b0;
      x_inv_q    <= 1'b0;
      op_inv_q   <= 1'b0;
      carry_in_q <= 1'b0;
      opcode_q   <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      alu_x_q    <= alu_x_d;
      opsel_q    <= opsel_d;
      a_inv_q    <= a_inv_d;
      x_inv_q    <= x_inv_d;
      op_inv_q   <= op_inv_d;
      carry_in_q <= carry_in_d;
      opcode_q   <= opcode_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.alu_a    = acc_q;
  assign bus.alu_x    = alu_x_q;
  assign bus.opsel    = opsel_q;
  assign bus.a_inv    = a_inv_q;
  assign bus.x_inv    = x_inv_q;
  assign bus.op_inv   = op_inv_q;
  assign bus.carry_in = carry_in_q;
  assign bus.acc      = acc_q;
  assign bus.flags    = flags_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
`default_nettype wire
